// File: rtl/airlock_ctrl.sv
// airlock_ctrl: bidirectional airlock sequencer with internal phase timer and door-breach fault recovery.
module airlock_ctrl #(
    parameter int ARRIVE_CYC = 5,
    parameter int EVAC_CYC   = 7,
    parameter int PRESS_CYC  = 8,
    parameter int CNT_W      = 8
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       arrive_req,
    input  logic       depart_req,
    input  logic       evac,
    input  logic       pressurize,
    input  logic       fault_clr,
    input  logic       inner_open,
    input  logic       outer_open,
    output logic       can_in,
    output logic       can_out,
    output logic [6:0] display,
    output logic       dir,
    output logic       busy,
    output logic       fault
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ARRIVE     = 3'd1;
    localparam logic [2:0] WAIT_EVAC  = 3'd2;
    localparam logic [2:0] EVAC       = 3'd3;
    localparam logic [2:0] OUTER_OPEN = 3'd4;
    localparam logic [2:0] PRESS      = 3'd5;
    localparam logic [2:0] INNER_OPEN = 3'd6;
    localparam logic [2:0] FAULT      = 3'd7;

    logic [2:0] ps, ns;
    logic [CNT_W-1:0] count, limit;
    logic closed, timed, expired;

    always_comb begin
        closed  = !inner_open && !outer_open;
        timed   = ps == ARRIVE || ps == EVAC || ps == PRESS;
        limit   = ps == ARRIVE ? CNT_W'(ARRIVE_CYC - 1) : ps == EVAC ? CNT_W'(EVAC_CYC - 1) : CNT_W'(PRESS_CYC - 1);
        expired = timed && count == limit;
    end

    // door-open check on EVAC/PRESS deliberately outranks timer expiry
    always_comb begin
        ns = ps;
        case (ps)
            IDLE:       ns = arrive_req ? ARRIVE : depart_req ? WAIT_EVAC : IDLE;
            ARRIVE:     ns = expired ? WAIT_EVAC : ARRIVE;
            WAIT_EVAC:  ns = evac && closed ? EVAC : WAIT_EVAC;
            EVAC:       ns = !closed ? FAULT : expired ? OUTER_OPEN : EVAC;
            OUTER_OPEN: ns = pressurize && closed ? PRESS : OUTER_OPEN;
            PRESS:      ns = !closed ? FAULT : expired ? (dir ? IDLE : INNER_OPEN) : PRESS;
            INNER_OPEN: ns = arrive_req ? INNER_OPEN : IDLE;
            FAULT:      ns = fault_clr && closed ? PRESS : FAULT;
            default:    ns = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            ps    <= IDLE;
            count <= '0;
            dir   <= 1'b0;
        end else begin
            ps    <= ns;
            count <= (ns != ps || !timed) ? '0 : count + 1'b1;
            if (ps == IDLE && ns != IDLE)
                dir <= ns == WAIT_EVAC;
        end
    end

    always_comb begin
        can_in  = ps == IDLE || ps == ARRIVE || ps == WAIT_EVAC || ps == INNER_OPEN;
        can_out = ps == OUTER_OPEN;
        display = ps == ARRIVE ? 7'b0001000 :
                  ps == EVAC   ? 7'b0000110 :
                  ps == PRESS  ? 7'b0001100 :
                  ps == FAULT  ? 7'b0001110 : 7'h7F;
        busy    = ps != IDLE;
        fault   = ps == FAULT;
    end
endmodule

// File: tb/tb_airlock_ctrl.sv
// tb_airlock_ctrl: scoreboard bench driving a default and a short-timer airlock with directed and random
// stimulus, checked against a countdown-based phase model.
module tb_airlock_ctrl;
    localparam logic [7:0] RST = 8'h80, ARR = 8'h40, DEP = 8'h20, EVC = 8'h10;
    localparam logic [7:0] PRS = 8'h08, CLR = 8'h04, INN = 8'h02, OUT = 8'h01;
    localparam int ARR_N [2] = '{5, 3};
    localparam int EVAC_N[2] = '{7, 2};
    localparam int PRES_N[2] = '{8, 3};

    typedef enum int {M_IDLE, M_ARRIVE, M_WAIT, M_EVAC, M_OUTER, M_PRESS, M_INNER, M_FAULT} phase_t;

    logic clock = 1'b0;
    logic rst = 1'b0, arriveReq = 1'b0, departReq = 1'b0, evac = 1'b0;
    logic pressurize = 1'b0, faultClr = 1'b0, innerOpen = 1'b0, outerOpen = 1'b0;
    logic       canIn [2], canOut [2], dirO [2], busy [2], fault [2];
    logic [6:0] display [2];

    phase_t mState [2];
    int     left [2];
    logic   mDir [2];
    logic [11:0] q0 [$];
    logic [11:0] q1 [$];
    int vectors = 0, miscompares = 0;

    always #5 clock = ~clock;

    airlock_ctrl dut0 (
        .clock(clock), .rst(rst), .arrive_req(arriveReq), .depart_req(departReq), .evac(evac),
        .pressurize(pressurize), .fault_clr(faultClr), .inner_open(innerOpen), .outer_open(outerOpen),
        .can_in(canIn[0]), .can_out(canOut[0]), .display(display[0]), .dir(dirO[0]), .busy(busy[0]), .fault(fault[0])
    );

    airlock_ctrl #(.ARRIVE_CYC(3), .EVAC_CYC(2), .PRESS_CYC(3), .CNT_W(2)) dut1 (
        .clock(clock), .rst(rst), .arrive_req(arriveReq), .depart_req(departReq), .evac(evac),
        .pressurize(pressurize), .fault_clr(faultClr), .inner_open(innerOpen), .outer_open(outerOpen),
        .can_in(canIn[1]), .can_out(canOut[1]), .display(display[1]), .dir(dirO[1]), .busy(busy[1]), .fault(fault[1])
    );

    function automatic logic [11:0] expOut(int k);
        logic ci, co;
        logic [6:0] seg;
        ci  = mState[k] inside {M_IDLE, M_ARRIVE, M_WAIT, M_INNER};
        co  = mState[k] == M_OUTER;
        seg = 7'h7F;
        if (mState[k] == M_ARRIVE) seg = 7'b0001000;
        if (mState[k] == M_EVAC)   seg = 7'b0000110;
        if (mState[k] == M_PRESS)  seg = 7'b0001100;
        if (mState[k] == M_FAULT)  seg = 7'b0001110;
        return {ci, co, seg, mDir[k], mState[k] != M_IDLE, mState[k] == M_FAULT};
    endfunction

    // Timed phases load their full length and count down; the last cycle is left == 1.
    task automatic step(int k, logic [7:0] v);
        logic closed;
        closed = !v[1] && !v[0];
        if (v[7]) begin
            mState[k] = M_IDLE;
            mDir[k] = 1'b0;
        end else begin
            case (mState[k])
                M_IDLE:
                    if (v[6]) begin mState[k] = M_ARRIVE; left[k] = ARR_N[k]; mDir[k] = 1'b0; end
                    else if (v[5]) begin mState[k] = M_WAIT; mDir[k] = 1'b1; end
                M_ARRIVE:
                    if (left[k] == 1) mState[k] = M_WAIT; else left[k]--;
                M_WAIT:
                    if (v[4] && closed) begin mState[k] = M_EVAC; left[k] = EVAC_N[k]; end
                M_EVAC:
                    if (!closed) mState[k] = M_FAULT;
                    else if (left[k] == 1) mState[k] = M_OUTER; else left[k]--;
                M_OUTER:
                    if (v[3] && closed) begin mState[k] = M_PRESS; left[k] = PRES_N[k]; end
                M_PRESS:
                    if (!closed) mState[k] = M_FAULT;
                    else if (left[k] == 1) mState[k] = mDir[k] ? M_IDLE : M_INNER; else left[k]--;
                M_INNER:
                    if (!v[6]) mState[k] = M_IDLE;
                M_FAULT:
                    if (v[2] && closed) begin mState[k] = M_PRESS; left[k] = PRES_N[k]; end
                default: mState[k] = M_IDLE;
            endcase
        end
    endtask

    task automatic drive(logic [7:0] v, int n);
        repeat (n) begin
            @(negedge clock);
            {rst, arriveReq, departReq, evac, pressurize, faultClr, innerOpen, outerOpen} = v;
            step(0, v);
            step(1, v);
            q0.push_back(expOut(0));
            q1.push_back(expOut(1));
        end
    endtask

    task automatic check(int k, logic [11:0] exp);
        logic [11:0] act;
        act = {canIn[k], canOut[k], display[k], dirO[k], busy[k], fault[k]};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL dut%0d outputs at %0t: got %03h expected %03h ({can_in,can_out,display,dir,busy,fault})",
                     k, $time, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        if (q0.size() > 0) check(0, q0.pop_front());
        if (q1.size() > 0) check(1, q1.pop_front());
    end

    initial begin
        mState = '{M_IDLE, M_IDLE};
        left   = '{0, 0};
        mDir   = '{1'b0, 1'b0};
        drive(RST, 2);
        // entering transit
        drive(ARR, 6); drive(ARR | EVC, 1); drive(ARR, 7); drive(ARR | PRS, 1); drive(ARR, 8); drive(0, 2);
        // exiting transit
        drive(DEP, 1); drive(DEP | EVC, 1); drive(0, 7); drive(PRS, 1); drive(0, 9);
        // interlock then advance on inner door closing
        drive(DEP, 1); drive(EVC | INN, 4); drive(EVC, 1); drive(0, 8); drive(PRS, 1); drive(0, 9);
        // breach on third EVAC cycle, supervised recovery
        drive(ARR, 6); drive(ARR | EVC, 1); drive(ARR, 2); drive(ARR | OUT, 1); drive(ARR, 2);
        drive(ARR | CLR | INN, 1); drive(ARR | CLR, 1); drive(ARR, 8); drive(0, 2);
        // simultaneous requests, breach on final PRESS cycle, reset mid-PRESS
        drive(ARR | DEP, 1); drive(ARR, 5); drive(EVC, 1); drive(0, 7); drive(PRS, 1); drive(0, 7);
        drive(INN, 1); drive(0, 1); drive(CLR, 1); drive(0, 3); drive(RST, 1); drive(0, 2);
        drive(PRS, 1); drive(DEP, 1); drive(EVC, 1); drive(0, 3); drive(PRS, 1); drive(0, 5);
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] v;
            v[7] = $urandom_range(0, 149) == 0;
            v[6] = $urandom_range(0, 9) < 4;
            v[5] = $urandom_range(0, 9) < 4;
            v[4] = $urandom_range(0, 1);
            v[3] = $urandom_range(0, 1);
            v[2] = $urandom_range(0, 1);
            v[1] = $urandom_range(0, 15) == 0;
            v[0] = $urandom_range(0, 15) == 0;
            drive(v, 1);
        end
        repeat (2) @(posedge clock);
        #2;
        if (q0.size() + q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/airlock_ctrl.md
# airlock_ctrl

Parametrised bidirectional airlock sequencer, next generation of the single-direction entry controller. Handles both entering (outside → inside) and exiting (inside → outside) transits, owns its phase timer internally with per-phase cycle counts, and adds door-breach fault detection with a supervised recovery path. Sits between the door sensors and pushbuttons on one side and the door-lock enables and 7-segment status display on the other.

## Interface

Parameters:
- ARRIVE_CYC, default 5: cycles spent in the ARRIVE phase (≥1).
- EVAC_CYC, default 7: cycles spent in the EVAC phase (≥1).
- PRESS_CYC, default 8: cycles spent in the PRESS phase (≥1).
- CNT_W, default 8: phase-counter width; must hold max(*_CYC)−1.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- arrive_req  in  1  craft at outer port requesting entry; level.
- depart_req  in  1  occupant requesting exit; level.
- evac  in  1  evacuate pushbutton; level.
- pressurize  in  1  pressurize pushbutton; level.
- fault_clr  in  1  operator fault acknowledge; level.
- inner_open  in  1  inner door sensor; 1 = open.
- outer_open  in  1  outer door sensor; 1 = open.
- can_in  out  1  inner door unlock enable.
- can_out  out  1  outer door unlock enable.
- display  out  7  active-low 7-segment code, segment order {g,f,e,d,c,b,a}.
- dir  out  1  latched transit direction: 0 = entering, 1 = exiting.
- busy  out  1  high in every state except IDLE.
- fault  out  1  high in FAULT only.

## Operation

- Moore FSM. Outputs decode from present state and dir only.
- States, with outputs can_in/can_out/display:
  - IDLE: 1/0/blank (7'h7F)
  - ARRIVE: 1/0/'A' (7'b0001000)
  - WAIT_EVAC: 1/0/blank
  - EVAC: 0/0/'E' (7'b0000110)
  - OUTER_OPEN: 0/1/blank
  - PRESS: 0/0/'P' (7'b0001100)
  - INNER_OPEN: 1/0/blank
  - FAULT: 0/0/'F' (7'b0001110)
- "closed" means !inner_open && !outer_open.
- Transitions:
  - IDLE → ARRIVE on arrive_req, with dir←0.
  - Otherwise IDLE → WAIT_EVAC on depart_req, with dir←1.
  - If arrive_req and depart_req are both asserted in IDLE, arrive_req wins.
  - ARRIVE → WAIT_EVAC when the phase timer expires.
  - WAIT_EVAC → EVAC on evac && closed. Otherwise WAIT_EVAC holds.
  - EVAC → OUTER_OPEN when the phase timer expires.
  - OUTER_OPEN → PRESS on pressurize && closed.
  - PRESS expires → INNER_OPEN if dir=0, else → IDLE.
  - INNER_OPEN → IDLE when arrive_req=0.
  - EVAC or PRESS with either door open → FAULT. This check takes priority over timer expiry in the same cycle.
  - FAULT → PRESS on fault_clr && closed. The recovery re-pressurizes, and dir is kept.
  - Illegal state encodings → IDLE.
- Phase timer:
  - An internal CNT_W-bit counter is cleared to 0 on every state change.
  - In timed states it increments once per cycle and expires when count == N−1, where N is the phase parameter.
  - In untimed states the counter holds at 0. It never wraps in a legal configuration.
- dir changes only on exit from IDLE.

## Timing

- Reset: ps=IDLE, count=0, dir=0, so can_in=1, can_out=0, display=7'h7F, busy=0, fault=0. These values are visible in the cycle after the rst edge.
- rst asserted mid-operation (any state) returns to IDLE at the next edge and overrides all inputs.
- Each timed phase occupies exactly N cycles: it is entered at edge t and left at edge t+N.
- Input-to-output latency is one clock. There are no combinational input→output paths.
- Buttons are level-sampled. A button held across a state entry is acted on immediately if its condition holds. No edge detection.

## Test plan

- Entering transit with default parameters:
  - Stimulus: arrive_req=1 at cycle 0; evac pulse with doors closed; pressurize pulse with doors closed; then drop arrive_req.
  - Required: display 'A' for exactly 5 cycles, 'E' for 7, can_out=1 until pressurize, 'P' for 8, then can_in=1. Returns to IDLE one cycle after arrive_req drops.
- Exiting transit:
  - Stimulus: depart_req=1, evac, pressurize.
  - Required: dir=1, no 'A' phase, 'E' for 7 cycles, OUTER_OPEN, 'P' for 8 cycles, then IDLE directly (no INNER_OPEN), busy=0.
- Interlock:
  - Stimulus: evac asserted while inner_open=1 in WAIT_EVAC.
  - Required: stays in WAIT_EVAC with display blank. Advances one cycle after inner_open drops with evac still high.
- Breach:
  - Stimulus: outer_open=1 at cycle 3 of EVAC.
  - Required: FAULT next cycle, fault=1, display 7'b0001110, both enables 0. Then fault_clr with doors closed → PRESS for 8 cycles → INNER_OPEN (dir=0).
- Simultaneous and timer-collision cases:
  - Stimulus: arrive_req and depart_req asserted together in IDLE.
  - Required: ARRIVE entered, dir=0.
  - Stimulus: door opens on the final PRESS cycle.
  - Required: FAULT, not the successor state.
- Reset mid-PRESS:
  - Stimulus: rst asserted during PRESS.
  - Required: next cycle IDLE, count=0, dir=0, can_in=1. With PRESS_CYC=3 and CNT_W=2 rerun, the 'P' phase lasts exactly 3 cycles.
